// File: rtl/adt7310_pkg.sv
// ----------------------------------------------------------------------------
// adt7310_pkg
// Shared definitions for the ADT7310 SPI responder: register addresses,
// command-byte bit positions, per-register read lengths and the FSM states.
// ----------------------------------------------------------------------------
package adt7310_pkg;

    // Register addresses (command bits 5:3)
    localparam logic [2:0] AddrStatus = 3'd0;
    localparam logic [2:0] AddrConfig = 3'd1;
    localparam logic [2:0] AddrTemp   = 3'd2;
    localparam logic [2:0] AddrId     = 3'd3;

    // Command byte bit positions
    localparam int CmdReadBit = 6;
    localparam int CmdContBit = 2;

    // Index of the last bit of a register word (bit count runs 0..N-1)
    localparam logic [3:0] LastBit8  = 4'd7;
    localparam logic [3:0] LastBit16 = 4'd15;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StRead,
        StWrite,
        StDone
    } state_t;

    // Only the temperature register is 16 bits wide; everything else is 8.
    function automatic logic [3:0] reg_last_bit(input logic [2:0] addr);
        return (addr == AddrTemp) ? LastBit16 : LastBit8;
    endfunction

endpackage

// File: rtl/adt7310_spi_responder_sync.sv
// ----------------------------------------------------------------------------
// spi_slave_sync
// Brings the asynchronous SPI pins into the Clk_i domain. SCK and CS_n pass
// through SyncStages flops followed by one more flop used for edge detection;
// MOSI gets the same synchronizer depth so it stays aligned with SCK.
//
// Ports:
//   Clk_i, Reset_n_i     clock, synchronous active-low reset
//   SPI_SCK_i            raw SPI clock (idles high)
//   SPI_MOSI_i           raw master-out data
//   CS_n_i               raw chip select, active-low
//   SCK_rise_o/fall_o    one-cycle strobes on synchronized SCK edges
//   MOSI_o               synchronized MOSI
//   CS_rise_o/fall_o     one-cycle strobes on synchronized CS_n edges
// SyncStages must be at least 2.
// ----------------------------------------------------------------------------
module spi_slave_sync #(
    parameter int SyncStages = 2
) (
    input  logic Clk_i,
    input  logic Reset_n_i,
    input  logic SPI_SCK_i,
    input  logic SPI_MOSI_i,
    input  logic CS_n_i,
    output logic SCK_rise_o,
    output logic SCK_fall_o,
    output logic MOSI_o,
    output logic CS_rise_o,
    output logic CS_fall_o
);

    logic [SyncStages-1:0] r_sck_sync;
    logic [SyncStages-1:0] r_mosi_sync;
    logic [SyncStages-1:0] r_cs_sync;
    logic [SyncStages-1:0] w_sck_next;
    logic [SyncStages-1:0] w_mosi_next;
    logic [SyncStages-1:0] w_cs_next;
    logic                  r_sck_prev;
    logic                  r_cs_prev;

    // Stage 0 takes the pin, every later stage takes its predecessor.
    genvar gi;
    generate
        for (gi = 0; gi < SyncStages; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign w_sck_next[gi]  = SPI_SCK_i;
                assign w_mosi_next[gi] = SPI_MOSI_i;
                assign w_cs_next[gi]   = CS_n_i;
            end else begin : g_chain
                assign w_sck_next[gi]  = r_sck_sync[gi-1];
                assign w_mosi_next[gi] = r_mosi_sync[gi-1];
                assign w_cs_next[gi]   = r_cs_sync[gi-1];
            end
        end
    endgenerate

    // Reset values match the idle bus: SCK high, CS_n high.
    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            r_sck_sync  <= '1;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sck_prev  <= 1'b1;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sck_sync  <= w_sck_next;
            r_mosi_sync <= w_mosi_next;
            r_cs_sync   <= w_cs_next;
            r_sck_prev  <= r_sck_sync[SyncStages-1];
            r_cs_prev   <= r_cs_sync[SyncStages-1];
        end
    end

    assign SCK_rise_o = r_sck_sync[SyncStages-1] & ~r_sck_prev;
    assign SCK_fall_o = ~r_sck_sync[SyncStages-1] & r_sck_prev;
    assign MOSI_o     = r_mosi_sync[SyncStages-1];
    assign CS_rise_o  = r_cs_sync[SyncStages-1] & ~r_cs_prev;
    assign CS_fall_o  = ~r_cs_sync[SyncStages-1] & r_cs_prev;

endmodule

// File: rtl/adt7310_spi_responder.sv
// ----------------------------------------------------------------------------
// adt7310_spi_responder
// SPI slave (CPOL=1, CPHA=1, MSB first) emulating the ADT7310 register
// interface: status (RDY_n), config (RW), 16-bit temperature and ID.
//
// Ports:
//   Clk_i, Reset_n_i             system clock (>= 8x SCK), sync active-low reset
//   SPI_SCK_i/MOSI_i/ADT7310CS_n_i  SPI bus from the master
//   SPI_MISO_o, SPI_MISOEn_o     slave data out and its drive enable
//   Temperature_i, TempValid_i   new conversion result and its strobe
//   Config_o, ConfigWrite_o      config register and its update pulse
//   Busy_o                       high from command start until CS_n rises
//
// Optional: define ADT7310_RESPONDER_CONT_READ_EN to enable continuous
// temperature reads (read command, bit2=1, addr=2).
// ----------------------------------------------------------------------------
module adt7310_spi_responder
    import adt7310_pkg::*;
#(
    parameter int         SyncStages = 2,
    parameter logic [7:0] DeviceID   = 8'hC3
) (
    input  logic        Clk_i,
    input  logic        Reset_n_i,
    input  logic        SPI_SCK_i,
    input  logic        SPI_MOSI_i,
    input  logic        ADT7310CS_n_i,
    output logic        SPI_MISO_o,
    output logic        SPI_MISOEn_o,
    input  logic [15:0] Temperature_i,
    input  logic        TempValid_i,
    output logic [7:0]  Config_o,
    output logic        ConfigWrite_o,
    output logic        Busy_o
);

    logic w_sck_rise;
    logic w_sck_fall;
    logic w_mosi;
    logic w_cs_rise;
    logic w_cs_fall;

    spi_slave_sync #(
        .SyncStages(SyncStages)
    ) u_sync (
        .Clk_i     (Clk_i),
        .Reset_n_i (Reset_n_i),
        .SPI_SCK_i (SPI_SCK_i),
        .SPI_MOSI_i(SPI_MOSI_i),
        .CS_n_i    (ADT7310CS_n_i),
        .SCK_rise_o(w_sck_rise),
        .SCK_fall_o(w_sck_fall),
        .MOSI_o    (w_mosi),
        .CS_rise_o (w_cs_rise),
        .CS_fall_o (w_cs_fall)
    );

    state_t      r_state;
    logic [3:0]  r_bit_cnt;
    logic [3:0]  r_cmd;          // {read, addr[2:0]} = command bits 6:3
    logic [6:0]  r_data;
    logic [15:0] r_shift;        // read data, left-aligned
    logic        r_miso;
    logic        r_miso_en;
    logic [7:0]  r_config;
    logic        r_config_write;
    logic [15:0] r_temp;
    logic        r_rdy_n;
    logic        r_pend_valid;
    logic [15:0] r_pend_temp;

    logic [2:0]  w_addr;
    logic [2:0]  w_cmd_addr;
    logic [3:0]  w_last_bit;
    logic [15:0] w_snapshot;
    logic        w_temp_lock;
    logic        w_cont;

    assign w_addr     = r_cmd[2:0];
    assign w_last_bit = reg_last_bit(w_addr);

    // On the 8th command rise r_cmd is complete (bits 2..0 are not stored).
    assign w_cmd_addr = r_cmd[2:0];

    // A temperature read in progress freezes r_temp until CS_n rises.
    assign w_temp_lock = ((r_state == StRead) || (r_state == StDone)) &&
                         r_cmd[CmdReadBit-3] && (w_addr == AddrTemp);

    always_comb begin
        w_snapshot = 16'h0000;
        case (w_cmd_addr)
            AddrStatus: w_snapshot = {r_rdy_n, 7'b0, 8'h00};
            AddrConfig: w_snapshot = {r_config, 8'h00};
            AddrTemp:   w_snapshot = r_temp;
            AddrId:     w_snapshot = {DeviceID, 8'h00};
            default:    w_snapshot = 16'h0000;
        endcase
    end

`ifdef ADT7310_RESPONDER_CONT_READ_EN
    logic r_cont;
    assign w_cont = r_cont && (w_addr == AddrTemp);

    // Continuous flag is captured as the command's bit 2 goes by.
    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            r_cont <= 1'b0;
        end else if (r_state == StCmd && w_sck_rise &&
                     r_bit_cnt == 4'(7 - CmdContBit)) begin
            r_cont <= w_mosi;
        end
    end
`else
    assign w_cont = 1'b0;
`endif

    always_ff @(posedge Clk_i) begin
        if (!Reset_n_i) begin
            r_state        <= StIdle;
            r_bit_cnt      <= '0;
            r_cmd          <= '0;
            r_data         <= '0;
            r_shift        <= '0;
            r_miso         <= 1'b1;
            r_miso_en      <= 1'b0;
            r_config       <= 8'h00;
            r_config_write <= 1'b0;
            r_temp         <= 16'h0000;
            r_rdy_n        <= 1'b1;
            r_pend_valid   <= 1'b0;
            r_pend_temp    <= 16'h0000;
        end else begin
            r_config_write <= 1'b0;

            if (TempValid_i) begin
                if (w_temp_lock) begin
                    r_pend_valid <= 1'b1;
                    r_pend_temp  <= Temperature_i;
                end else begin
                    r_temp  <= Temperature_i;
                    r_rdy_n <= 1'b0;
                end
            end

            if (w_cs_rise) begin
                // End of transfer beats everything else, including SCK.
                r_state   <= StIdle;
                r_miso    <= 1'b1;
                r_miso_en <= 1'b0;
                if (TempValid_i) begin
                    r_temp  <= Temperature_i;
                    r_rdy_n <= 1'b0;
                end else if (r_pend_valid) begin
                    r_temp  <= r_pend_temp;
                    r_rdy_n <= 1'b0;
                end
                r_pend_valid <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (w_cs_fall) begin
                            r_state   <= StCmd;
                            r_bit_cnt <= '0;
                            r_miso_en <= 1'b1;
                        end
                    end

                    StCmd: begin
                        if (w_sck_rise) begin
                            // Keep only command bits 6..3; bit 7 falls out.
                            if (r_bit_cnt <= 4'd4) begin
                                r_cmd <= {r_cmd[2:0], w_mosi};
                            end
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt <= '0;
                                if (r_cmd[CmdReadBit-3]) begin
                                    r_state <= StRead;
                                    r_shift <= w_snapshot;
                                end else begin
                                    r_state <= StWrite;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end

                    StRead: begin
                        if (w_sck_fall) begin
                            r_miso  <= r_shift[15];
                            r_shift <= {r_shift[14:0], 1'b0};
                        end else if (w_sck_rise) begin
                            if (r_bit_cnt == w_last_bit) begin
                                r_bit_cnt <= '0;
                                if (w_addr == AddrTemp) begin
                                    r_rdy_n <= 1'b1;
                                end
                                if (w_cont) begin
                                    // Word boundary: pick up any deferred update.
                                    if (r_pend_valid) begin
                                        r_shift <= r_pend_temp;
                                        r_temp  <= r_pend_temp;
                                        if (!TempValid_i) begin
                                            r_pend_valid <= 1'b0;
                                        end
                                    end else begin
                                        r_shift <= r_temp;
                                    end
                                end else begin
                                    r_state <= StDone;
                                    r_miso  <= 1'b0;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end

                    StWrite: begin
                        if (w_sck_rise) begin
                            r_data <= {r_data[5:0], w_mosi};
                            if (r_bit_cnt == 4'd7) begin
                                if (w_addr == AddrConfig) begin
                                    r_config       <= {r_data, w_mosi};
                                    r_config_write <= 1'b1;
                                end
                                r_state <= StDone;
                                r_miso  <= 1'b0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end

                    StDone: begin
                        r_miso <= 1'b0;
                    end

                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign SPI_MISO_o    = r_miso;
    assign SPI_MISOEn_o  = r_miso_en;
    assign Config_o      = r_config;
    assign ConfigWrite_o = r_config_write;
    assign Busy_o        = (r_state != StIdle);

endmodule

// File: tb/tb_adt7310_spi_responder.sv
// ----------------------------------------------------------------------------
// tb_adt7310_spi_responder
// Drives SPI transfers as a mode-3 master, predicts read words and config
// writes from a register-level model, and compares through queues drained
// by independent monitor processes.
// ----------------------------------------------------------------------------
module tb_adt7310_spi_responder;

    localparam int SYNC = 2;
    localparam int HALF = 8;   // Clk_i cycles per SCK half period

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sck = 1'b1;
    logic        mosi = 1'b0;
    logic        cs_n = 1'b1;
    logic        tv = 1'b0;
    logic [15:0] temp_in = 16'h0000;
    logic        miso;
    logic        miso_en;
    logic [7:0]  cfg;
    logic        cfg_wr;
    logic        busy;

    always #5 clk = ~clk;

    adt7310_spi_responder #(
        .SyncStages(SYNC),
        .DeviceID  (8'hC3)
    ) dut (
        .Clk_i        (clk),
        .Reset_n_i    (rst_n),
        .SPI_SCK_i    (sck),
        .SPI_MOSI_i   (mosi),
        .ADT7310CS_n_i(cs_n),
        .SPI_MISO_o   (miso),
        .SPI_MISOEn_o (miso_en),
        .Temperature_i(temp_in),
        .TempValid_i  (tv),
        .Config_o     (cfg),
        .ConfigWrite_o(cfg_wr),
        .Busy_o       (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard queues
    logic [15:0] exp_q[$];
    logic [15:0] act_q[$];
    string       name_q[$];
    logic [7:0]  cfg_exp_q[$];

    // Register-level model of the sensor
    logic [7:0]  m_config = 8'h00;
    logic [15:0] m_temp   = 16'h0000;
    logic [15:0] m_pend   = 16'h0000;
    bit          m_pend_v = 1'b0;
    bit          m_rdy_n  = 1'b1;
    bit          m_locked = 1'b0;

    function automatic void model_tv(input logic [15:0] v);
        if (m_locked) begin
            m_pend   = v;
            m_pend_v = 1'b1;
        end else begin
            m_temp  = v;
            m_rdy_n = 1'b0;
        end
    endfunction

    function automatic logic [15:0] model_reg(input logic [2:0] a);
        case (a)
            3'd0:    return {8'h00, m_rdy_n, 7'b0};
            3'd1:    return {8'h00, m_config};
            3'd2:    return m_temp;
            3'd3:    return 16'h00C3;
            default: return 16'h0000;
        endcase
    endfunction

    // Read-data monitor
    initial forever begin
        @(negedge clk);
        while (act_q.size() > 0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_unexpected: got %h expected nothing", act_q.pop_front());
            end else begin
                check(name_q.pop_front(), act_q.pop_front(), exp_q.pop_front());
            end
        end
    end

    // Config-write monitor
    initial forever begin
        @(negedge clk);
        if (cfg_wr) begin
            if (cfg_exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL cfg_pulse_unexpected: Config_o %h expected no pulse", cfg);
            end else begin
                check("cfg_write", {8'h00, cfg}, {8'h00, cfg_exp_q.pop_front()});
            end
        end
    end

    task automatic pulse_temp(input logic [15:0] v);
        @(negedge clk);
        temp_in = v;
        tv      = 1'b1;
        model_tv(v);
        @(negedge clk);
        tv = 1'b0;
        $display("TEMP  strobe %h", v);
    endtask

    // One CS_n-framed transfer: command byte then nbits data bits. A
    // TempValid strobe can be injected at up to two data-bit positions.
    task automatic xfer(input logic [7:0] cmd, input int nbits, input logic [7:0] wdata,
                        input int tb0, input logic [15:0] tv0,
                        input int tb1, input logic [15:0] tv1);
        logic [2:0]  addr;
        bit          rd;
        bit          cont;
        int          w;
        int          j;
        int          k;
        logic [15:0] rx;
        addr = cmd[5:3];
        rd   = cmd[6];
        cont = 1'b0;
`ifdef ADT7310_RESPONDER_CONT_READ_EN
        cont = rd && cmd[2] && (addr == 3'd2);
`endif
        w  = (addr == 3'd2) ? 16 : 8;
        rx = 16'h0000;
        k  = 0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 8 + nbits; i++) begin
            j    = i - 8;
            sck  = 1'b0;
            mosi = (i < 8) ? cmd[7-i] : ((!rd && j < 8) ? wdata[7-j] : 1'b0);
            if (rd && j >= 0 && (j == tb0 || j == tb1)) begin
                temp_in = (j == tb0) ? tv0 : tv1;
                tv      = 1'b1;
                model_tv(temp_in);
                @(negedge clk);
                tv = 1'b0;
                repeat (HALF - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sck = 1'b1;
            if (i == 7 && rd) begin
                if (addr == 3'd2) m_locked = 1'b1;
                exp_q.push_back(model_reg(addr));
                name_q.push_back($sformatf("rd_a%0d_w0", addr));
            end
            if (!rd && j == 7 && addr == 3'd1) begin
                m_config = wdata;
                cfg_exp_q.push_back(wdata);
            end
            if (rd && j >= 0) begin
                rx = {rx[14:0], miso};
                if ((j + 1) % w == 0) begin
                    act_q.push_back(w == 16 ? rx : {8'h00, rx[7:0]});
                    k++;
                    if (addr == 3'd2) begin
                        m_rdy_n = 1'b1;
                        if (cont && m_pend_v) begin
                            m_temp   = m_pend;
                            m_pend_v = 1'b0;
                        end
                    end
                    if (j + 1 < nbits) begin
                        exp_q.push_back(cont ? m_temp : 16'h0000);
                        name_q.push_back($sformatf("rd_a%0d_w%0d", addr, k));
                    end
                end
            end
            repeat (HALF) @(negedge clk);
            if (i == 7) begin
                check("busy_mid", {15'b0, busy}, 16'd1);
                check("misoen_mid", {15'b0, miso_en}, 16'd1);
            end
        end
        cs_n = 1'b1;
        m_locked = 1'b0;
        if (m_pend_v) begin
            m_temp   = m_pend;
            m_rdy_n  = 1'b0;
            m_pend_v = 1'b0;
        end
        repeat (SYNC + 2) @(negedge clk);
        check("misoen_after_cs", {15'b0, miso_en}, 16'd0);
        check("busy_after_cs", {15'b0, busy}, 16'd0);
        check("miso_after_cs", {15'b0, miso}, 16'd1);
        $display("XFER  cmd %h bits %0d wdata %h rx %h", cmd, nbits, wdata, rx);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [15:0] t2;
        logic [15:0] t3;
        repeat (4) @(negedge clk);
        check("rst_config", {8'h00, cfg}, 16'h0000);
        check("rst_misoen", {15'b0, miso_en}, 16'd0);
        check("rst_miso", {15'b0, miso}, 16'd1);
        check("rst_busy", {15'b0, busy}, 16'd0);
        check("rst_cfgwr", {15'b0, cfg_wr}, 16'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        xfer(8'h58, 8, 8'h00, -1, 16'h0, -1, 16'h0);   // ID
        xfer(8'h40, 8, 8'h00, -1, 16'h0, -1, 16'h0);   // status after reset
        xfer(8'h50, 16, 8'h00, -1, 16'h0, -1, 16'h0);  // temp after reset
        pulse_temp(16'h1A40);
        xfer(8'h40, 8, 8'h00, -1, 16'h0, -1, 16'h0);   // RDY_n cleared
        xfer(8'h50, 16, 8'h00, -1, 16'h0, -1, 16'h0);
        xfer(8'h40, 8, 8'h00, -1, 16'h0, -1, 16'h0);   // RDY_n set again
        xfer(8'h08, 8, 8'hA5, -1, 16'h0, -1, 16'h0);   // config write
        xfer(8'h48, 8, 8'h00, -1, 16'h0, -1, 16'h0);
        xfer(8'h08, 4, 8'h3C, -1, 16'h0, -1, 16'h0);   // aborted write
        check("cfg_after_abort", {8'h00, cfg}, {8'h00, m_config});
        xfer(8'h48, 8, 8'h00, -1, 16'h0, -1, 16'h0);
        xfer(8'h50, 16, 8'h00, 6, 16'h0BEE, -1, 16'h0); // deferred update
        xfer(8'h50, 16, 8'h00, -1, 16'h0, -1, 16'h0);
        xfer(8'h98, 8, 8'h00, -1, 16'h0, -1, 16'h0);   // ID with bit7 set

        t2 = 16'($urandom);
        t3 = 16'($urandom);
        xfer(8'h54, 48, 8'h00, 4, t2, 20, t3);         // 3-word temp read
        xfer(8'h50, 16, 8'h00, -1, 16'h0, -1, 16'h0);

        for (int t = 0; t < 24; t++) begin
            int         op;
            int         nb;
            int         tb;
            logic [2:0] a;
            logic [7:0] c;
            op = int'($urandom_range(0, 4));
            a  = 3'($urandom_range(0, 7));
            c  = {1'($urandom_range(0, 1)), 1'b0, a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
            case (op)
                0, 1: begin
                    c[6] = 1'b1;
                    nb   = (a == 3'd2) ? 16 : 8;
                    tb   = (a == 3'd2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 14)) : -1;
                    xfer(c, nb, 8'h00, tb, 16'($urandom), -1, 16'h0);
                end
                2: xfer(c, 8, 8'($urandom), -1, 16'h0, -1, 16'h0);
                3: xfer(c, int'($urandom_range(1, 7)), 8'($urandom), -1, 16'h0, -1, 16'h0);
                default: pulse_temp(16'($urandom));
            endcase
        end
        xfer(8'h48, 8, 8'h00, -1, 16'h0, -1, 16'h0);
        xfer(8'h50, 16, 8'h00, -1, 16'h0, -1, 16'h0);

        repeat (10) @(negedge clk);
        check("exp_q_drained", 16'(exp_q.size()), 16'd0);
        check("cfg_q_drained", 16'(cfg_exp_q.size()), 16'd0);
        check("cfg_final", {8'h00, cfg}, {8'h00, m_config});
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
